// File: rtl/bcd_frame_conv_if.sv
// Purpose: handshake/data bundle between a frame-rate requester and the
// shared binary-to-BCD converter.
//   start    : request a conversion (honoured only while the converter is idle)
//   blank_lz : leading-zero blanking enable, captured together with start
//   bin      : CH packed binary values, channel c at [c*N_IN +: N_IN]
//   busy     : conversion in progress
//   done     : one-cycle pulse when dec/ovf take a new frame
//   dec      : CH packed BCD words, channel c at [c*DIGITS*4 +: DIGITS*4]
//   ovf      : per-channel saturation flags
interface bcd_frame_conv_if #(
  parameter int unsigned N_IN   = 10,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned CH     = 3
);
  logic                     start;
  logic                     blank_lz;
  logic [CH*N_IN-1:0]       bin;
  logic                     busy;
  logic                     done;
  logic [CH*DIGITS*4-1:0]   dec;
  logic [CH-1:0]            ovf;

  modport master (
    output start, blank_lz, bin,
    input  busy, done, dec, ovf
  );

  modport slave (
    input  start, blank_lz, bin,
    output busy, done, dec, ovf
  );
endinterface

// File: rtl/bcd_frame_conv.sv
// Purpose: multi-channel sequential binary-to-BCD converter for the VGA text
// path. One shift-add-3 engine walks all channels of a captured snapshot,
// results collect in a shadow buffer and are published to dec/ovf in a single
// cycle so the display never sees a partially converted frame.
// Ports:
//   clk  : clock
//   RSTn : asynchronous active-low reset
//   bus  : bcd_frame_conv_if.slave (start, blank_lz, bin in; busy, done, dec, ovf out)
module bcd_frame_conv #(
  parameter int unsigned N_IN   = 10,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned CH     = 3,
  parameter logic [3:0]  BLANK  = 4'hA
) (
  input  logic             clk,
  input  logic             RSTn,
  bcd_frame_conv_if.slave  bus
);

  localparam int unsigned DW = DIGITS * 4;
  localparam int unsigned BW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CH*N_IN-1:0] bin_snap_q, bin_snap_d;
  logic               blank_q, blank_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DW-1:0]      bcd_q, bcd_d;
  logic [N_IN-1:0]    sh_q, sh_d;
  logic               sticky_q, sticky_d;
  logic [CH*DW-1:0]   shadow_q, shadow_d;
  logic [CH-1:0]      shadow_ovf_q, shadow_ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CH*DW-1:0]   dec_q, dec_d;
  logic [CH-1:0]      ovf_q, ovf_d;

  logic [DW-1:0]      adj;
  logic [DW-1:0]      word;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [DW-1:0] add3(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (v[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = v[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Replace zero digits above the units digit, scanning down from the top
  // until the first non-zero digit.
  function automatic logic [DW-1:0] blank_lead(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
      if (lead && (v[d*4 +: 4] == 4'd0)) r[d*4 +: 4] = BLANK;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d      = state_q;
    bin_snap_d   = bin_snap_q;
    blank_d      = blank_q;
    ch_d         = ch_q;
    bit_d        = bit_q;
    bcd_d        = bcd_q;
    sh_d         = sh_q;
    sticky_d     = sticky_q;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    dec_d        = dec_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    adj          = add3(bcd_q);
    word         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_snap_d = bus.bin;
          blank_d    = bus.blank_lz;
          ch_d       = '0;
          bit_d      = '0;
          bcd_d      = '0;
          sticky_d   = 1'b0;
          sh_d       = bus.bin[N_IN-1:0];
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A 1 leaving the top digit means the value needs more digits.
        sticky_d = sticky_q | adj[DW-1];
        bcd_d    = {adj[DW-2:0], sh_q[N_IN-1]};
        sh_d     = sh_q << 1;
        if (bit_q == BW'(N_IN - 1)) state_d = S_STORE;
        else                        bit_d   = BW'(bit_q + 1'b1);
      end

      S_STORE: begin
        if (sticky_q)     word = {DIGITS{4'h9}};
        else if (blank_q) word = blank_lead(bcd_q);
        else              word = bcd_q;
        shadow_d[int'(ch_q)*DW +: DW] = word;
        shadow_ovf_d[ch_q]            = sticky_q;
        if (ch_q == CW'(CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d     = CW'(ch_q + 1'b1);
          bit_d    = '0;
          bcd_d    = '0;
          sticky_d = 1'b0;
          sh_d     = bin_snap_q[int'(ch_d)*N_IN +: N_IN];
          state_d  = S_SHIFT;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so they are valid in the same cycle as it.
    busy_d = (state_d != S_IDLE);
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      dec_d  = shadow_d;
      ovf_d  = shadow_ovf_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      bin_snap_q   <= '0;
      blank_q      <= 1'b0;
      ch_q         <= '0;
      bit_q        <= '0;
      bcd_q        <= '0;
      sh_q         <= '0;
      sticky_q     <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dec_q        <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      bin_snap_q   <= bin_snap_d;
      blank_q      <= blank_d;
      ch_q         <= ch_d;
      bit_q        <= bit_d;
      bcd_q        <= bcd_d;
      sh_q         <= sh_d;
      sticky_q     <= sticky_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dec_q        <= dec_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dec  = dec_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_frame_conv.sv
module tb_bcd_frame_conv;

  localparam int A_LAT = 3 * (10 + 1) + 1;
  localparam int B_LAT = 2 * (14 + 1) + 1;

  typedef struct packed {
    logic [35:0] dec;
    logic [2:0]  ovf;
  } exp_a_t;

  typedef struct packed {
    logic [31:0] dec;
    logic [1:0]  ovf;
  } exp_b_t;

  logic clk;
  logic RSTn;
  int   checks = 0;
  int   errors = 0;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  bcd_frame_conv_if #(.N_IN(10), .DIGITS(3), .CH(3)) ifa ();
  bcd_frame_conv_if #(.N_IN(14), .DIGITS(4), .CH(2)) ifb ();

  bcd_frame_conv #(.N_IN(10), .DIGITS(3), .CH(3), .BLANK(4'hA)) dut_a (
    .clk (clk),
    .RSTn(RSTn),
    .bus (ifa.slave)
  );

  bcd_frame_conv #(.N_IN(14), .DIGITS(4), .CH(2), .BLANK(4'hA)) dut_b (
    .clk (clk),
    .RSTn(RSTn),
    .bus (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion by decimal arithmetic; up to 4 digits.
  function automatic logic [15:0] ref_digits(input int unsigned v, input int nd,
                                             input logic bl, output logic o);
    logic [15:0] r;
    int unsigned t;
    r = '0;
    o = 1'b0;
    if (v >= 10 ** nd) begin
      o = 1'b1;
      for (int d = 0; d < nd; d++) r[d*4 +: 4] = 4'h9;
    end else begin
      t = v;
      for (int d = 0; d < nd; d++) begin
        r[d*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
      if (bl) begin
        for (int d = nd - 1; d >= 1; d--) begin
          if (r[d*4 +: 4] != 4'd0) break;
          r[d*4 +: 4] = 4'hA;
        end
      end
    end
    return r;
  endfunction

  function automatic exp_a_t model_a(input logic [9:0] c0, input logic [9:0] c1,
                                     input logic [9:0] c2, input logic bl);
    exp_a_t      e;
    logic [15:0] w;
    logic        o;
    w = ref_digits(int'(c0), 3, bl, o); e.dec[11:0]  = w[11:0]; e.ovf[0] = o;
    w = ref_digits(int'(c1), 3, bl, o); e.dec[23:12] = w[11:0]; e.ovf[1] = o;
    w = ref_digits(int'(c2), 3, bl, o); e.dec[35:24] = w[11:0]; e.ovf[2] = o;
    return e;
  endfunction

  // One conversion on the default instance, with bin/blank scrambled after accept.
  task automatic run_a(input logic [9:0] c0, input logic [9:0] c1,
                       input logic [9:0] c2, input logic bl);
    exp_a_t      e;
    logic [35:0] prev;
    int          cyc;
    logic        stable;
    q_a.push_back(model_a(c0, c1, c2, bl));
    prev         = ifa.dec;
    ifa.bin      = {c2, c1, c0};
    ifa.blank_lz = bl;
    ifa.start    = 1'b1;
    @(posedge clk); #1;
    ifa.start    = 1'b0;
    ifa.bin      = 30'($urandom);
    ifa.blank_lz = ~bl;
    cyc    = 1;
    stable = 1'b1;
    while (ifa.done !== 1'b1 && cyc < 200) begin
      if (ifa.dec !== prev || ifa.busy !== 1'b1) stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("a_latency", 64'(cyc), 64'(A_LAT));
    check("a_busy_stable_dec", 64'(stable), 64'd1);
    e = q_a.pop_front();
    check("a_dec", 64'(ifa.dec), 64'(e.dec));
    check("a_ovf", 64'(ifa.ovf), 64'(e.ovf));
    @(posedge clk); #1;
    check("a_idle_after", 64'({ifa.busy, ifa.done}), 64'd0);
  endtask

  task automatic run_b(input logic [13:0] c0, input logic [13:0] c1, input logic bl);
    exp_b_t      e;
    logic [15:0] w;
    logic        o;
    int          cyc;
    w = ref_digits(int'(c0), 4, bl, o); e.dec[15:0]  = w; e.ovf[0] = o;
    w = ref_digits(int'(c1), 4, bl, o); e.dec[31:16] = w; e.ovf[1] = o;
    q_b.push_back(e);
    ifb.bin      = {c1, c0};
    ifb.blank_lz = bl;
    ifb.start    = 1'b1;
    @(posedge clk); #1;
    ifb.start    = 1'b0;
    ifb.bin      = 28'($urandom);
    cyc = 1;
    while (ifb.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b_latency", 64'(cyc), 64'(B_LAT));
    e = q_b.pop_front();
    check("b_dec", 64'(ifb.dec), 64'(e.dec));
    check("b_ovf", 64'(ifb.ovf), 64'(e.ovf));
    @(posedge clk); #1;
  endtask

  initial begin
    exp_a_t e;
    int     cyc;
    int     last;
    int     n;
    logic   seen;

    ifa.start = 1'b0; ifa.blank_lz = 1'b0; ifa.bin = '0;
    ifb.start = 1'b0; ifb.blank_lz = 1'b0; ifb.bin = '0;
    RSTn = 1'b1;
    #2 RSTn = 1'b0;
    #1;
    check("rst_busy", 64'(ifa.busy), 64'd0);
    check("rst_done", 64'(ifa.done), 64'd0);
    check("rst_dec", 64'(ifa.dec), 64'd0);
    check("rst_ovf", 64'(ifa.ovf), 64'd0);
    check("rst_dec_b", 64'(ifb.dec), 64'd0);
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;
    @(posedge clk); #1;

    // Saturation on 1023, zero channel, boundary 999
    run_a(10'd1023, 10'd0, 10'd999, 1'b0);
    // Leading-zero blanking
    run_a(10'd7, 10'd50, 10'd305, 1'b1);
    // Zero with and without blanking, 1000 boundary
    run_a(10'd0, 10'd0, 10'd0, 1'b1);
    run_a(10'd1000, 10'd100, 10'd0, 1'b0);
    run_a(10'd10, 10'd1, 10'd1000, 1'b1);

    // Start held high: back-to-back conversions every A_LAT+1 cycles
    ifa.bin      = {10'd123, 10'd456, 10'd789};
    ifa.blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) q_a.push_back(model_a(10'd789, 10'd456, 10'd123, 1'b0));
    ifa.start = 1'b1;
    cyc = 0; last = 0; n = 0;
    while (n < 3 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (ifa.done === 1'b1) begin
        if (n == 0) check("held_first_latency", 64'(cyc), 64'(A_LAT));
        else        check("held_interval", 64'(cyc - last), 64'(A_LAT + 1));
        e = q_a.pop_front();
        check("held_dec", 64'(ifa.dec), 64'(e.dec));
        last = cyc;
        n++;
      end
    end
    ifa.start = 1'b0;
    check("held_count", 64'(n), 64'd3);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a conversion
    ifa.bin   = {10'd3, 10'd2, 10'd1};
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("midrst_busy_before", 64'(ifa.busy), 64'd1);
    RSTn = 1'b0;
    #1;
    check("midrst_busy", 64'(ifa.busy), 64'd0);
    check("midrst_done", 64'(ifa.done), 64'd0);
    check("midrst_dec", 64'(ifa.dec), 64'd0);
    check("midrst_ovf", 64'(ifa.ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ifa.done === 1'b1 || ifa.busy === 1'b1) seen = 1'b1;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_a(10'd42, 10'd999, 10'd512, 1'b1);

    // Wider instance: directed boundaries then random sweep
    run_b(14'd9999, 14'd10000, 1'b0);
    run_b(14'd0, 14'd16383, 1'b1);
    run_b(14'd10, 14'd100, 1'b1);
    run_b(14'd0, 14'd9, 1'b0);
    for (int i = 0; i < 16; i++)
      run_b(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
            1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
